// File: rtl/vcve2_instr_bus_responder.sv
// Instruction-fetch bus target: grants requests, reads a 1-cycle-latency SRAM and
// returns in-order responses no earlier than RESP_LATENCY cycles after the grant.
module vcve2_instr_bus_responder #(
  parameter int unsigned MEM_ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  stall_i,
  output logic                  mem_req_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]  AGE_SAT = (RESP_LATENCY > 7) ? 3'd7 : 3'(RESP_LATENCY);
  localparam logic [3:0]  LAT     = 4'(RESP_LATENCY);
  localparam logic [2:0]  DEPTH   = 3'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [2:0]  age;
    logic [31:0] rdata;
  } entry_t;

  entry_t           q [MAX_OUTSTANDING];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [2:0]       count;
  logic             in_range, push, pop;
  logic             unused_addr;

  assign unused_addr = ^instr_addr_i[1:0];

  assign in_range    = (instr_addr_i[31:MEM_ADDR_W+2] == BASE_ADDR[31:MEM_ADDR_W+2]);
  // Gated by reset so the bus sees no grant while the queue is being cleared.
  assign instr_gnt_o = ~rst_i & instr_req_i & ~stall_i & (count < DEPTH);
  assign mem_req_o   = instr_gnt_o & in_range;
  assign mem_addr_o  = instr_addr_i[MEM_ADDR_W+1:2];

  assign head = q[rd_ptr];
  // Registered age lags the grant by one cycle, hence the +1.
  assign instr_rvalid_o = head.valid & (({1'b0, head.age} + 4'd1) >= LAT);
  assign instr_err_o    = head.err & instr_rvalid_o;
  assign busy_o         = (count != 3'd0);

  always_comb begin
    instr_rdata_o = 32'h0;
    if (instr_rvalid_o) begin
      if (head.age == 3'd0 && !head.err) instr_rdata_o = mem_rdata_i;
      else                               instr_rdata_o = head.rdata;
    end
  end

  assign push = instr_gnt_o;
  assign pop  = instr_rvalid_o;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (push && wr_ptr == PTR_W'(i)) begin
          q[i].valid <= 1'b1;
          q[i].err   <= ~in_range;
          q[i].age   <= 3'd0;
          q[i].rdata <= 32'h0;
        end else if (pop && rd_ptr == PTR_W'(i)) begin
          q[i].valid <= 1'b0;
        end else if (q[i].valid) begin
          if (q[i].age != AGE_SAT) q[i].age <= q[i].age + 3'd1;
          // SRAM data for the entry pushed last cycle arrives now.
          if (q[i].age == 3'd0 && !q[i].err) q[i].rdata <= mem_rdata_i;
        end
      end
    end
  end

endmodule
